// File: rtl/data_mem_lsu.sv
// Load/store unit with internal data RAM. It accepts one request at a time over valid/ready.
// It applies byte lanes on stores, extends sub-word loads, and inserts LATENCY wait states.
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | aligned access accepted, counting down wait states
// RESP  | one-cycle response pulse
module data_mem_lsu #(
  parameter int MEM_DEPTH = 1024,
  parameter int LATENCY   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misalign,
  output logic        busy
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [2:0] CNT_INIT = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state, state_n;
  logic [2:0]    cnt;
  logic [31:0]   mem [MEM_DEPTH];

  logic          r_we, r_unsigned;
  logic [1:0]    r_size;
  logic [AW+1:0] r_addr;
  logic [31:0]   r_wdata;

  logic          cur_we, cur_unsigned;
  logic [1:0]    cur_size;
  logic [AW+1:0] cur_addr;
  logic [31:0]   cur_wdata;
  logic [AW-1:0] cur_idx;

  logic          accept, misalign, commit;
  logic [31:0]   rword, shifted, load_val, wd, wmask, wnew;
  logic [3:0]    be;

  logic unused_addr;
  assign unused_addr = ^req_addr[31:AW+2];

  // In IDLE the access (LATENCY = 0 or fault check) uses the live request; afterwards the latched copy.
  always_comb begin
    cur_we       = r_we;
    cur_unsigned = r_unsigned;
    cur_size     = r_size;
    cur_addr     = r_addr;
    cur_wdata    = r_wdata;
    if (state == IDLE) begin
      cur_we       = req_we;
      cur_unsigned = req_unsigned;
      cur_size     = req_size;
      cur_addr     = req_addr[AW+1:0];
      cur_wdata    = req_wdata;
    end
  end

  assign cur_idx  = cur_addr[AW+1:2];
  assign misalign = ((cur_size == 2'b01) && cur_addr[0]) ||
                    (cur_size[1] && (cur_addr[1:0] != 2'b00));

  always_comb begin
    state_n    = state;
    commit     = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    busy       = (state != IDLE);
    accept     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !reset;
        accept    = req_valid && !reset;
        if (accept) begin
          if (misalign)          state_n = RESP;
          else if (LATENCY == 0) begin
            commit  = 1'b1;
            state_n = RESP;
          end
          else                   state_n = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 3'd0) begin
          commit  = 1'b1;
          state_n = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    rword   = mem[cur_idx];
    shifted = rword >> {cur_addr[1:0], 3'b000};
    case (cur_size)
      2'b00:   load_val = cur_unsigned ? {24'b0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = cur_unsigned ? {16'b0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
      default: load_val = rword;
    endcase
  end

  always_comb begin
    case (cur_size)
      2'b00: begin
        be = 4'b0001 << cur_addr[1:0];
        wd = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        be = cur_addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{cur_wdata[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = cur_wdata;
      end
    endcase
    wmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    wnew  = (rword & ~wmask) | (wd & wmask);
  end

  always_ff @(posedge clk) begin
    if (!reset && commit && cur_we)
      mem[cur_idx] <= wnew;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= 3'd0;
      resp_rdata    <= 32'd0;
      resp_misalign <= 1'b0;
    end else begin
      state <= state_n;
      if (accept)               cnt <= CNT_INIT;
      else if (state == WAIT)   cnt <= cnt - 3'd1;
      if (commit) begin
        resp_rdata    <= cur_we ? 32'd0 : load_val;
        resp_misalign <= 1'b0;
      end else if (accept && misalign) begin
        resp_rdata    <= 32'd0;
        resp_misalign <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      r_we       <= req_we;
      r_size     <= req_size;
      r_unsigned <= req_unsigned;
      r_addr     <= req_addr[AW+1:0];
      r_wdata    <= req_wdata;
    end
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu: unit 1 runs with LATENCY = 1 and unit 0 with LATENCY = 0.
// Expected values are hand-computed constants.
module tb_data_mem_lsu;

  logic        clk;
  logic [1:0]  reset;
  logic [1:0]  req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  resp_valid, resp_misalign, busy;
  logic [1:0]  req_size  [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [31:0] resp_rdata[2];

  int checks = 0;
  int errors = 0;

  data_mem_lsu #(.MEM_DEPTH(1024), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]),
    .resp_rdata(resp_rdata[0]), .resp_misalign(resp_misalign[0]), .busy(busy[0]));

  data_mem_lsu #(.MEM_DEPTH(1024), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]),
    .resp_rdata(resp_rdata[1]), .resp_misalign(resp_misalign[1]), .busy(busy[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one request, then scrambles the inputs after acceptance.
  // lat counts negedges from acceptance to the response.
  task automatic do_req(input int u, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic mis, output int lat,
                        output logic pv, output logic [31:0] prd);
    int n;
    @(negedge clk);
    req_valid[u] = 1'b1; req_we[u] = we; req_size[u] = size;
    req_unsigned[u] = uns; req_addr[u] = addr; req_wdata[u] = wdata;
    n = 0;
    while (!req_ready[u] && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    req_valid[u] = 1'b0; req_we[u] = ~we; req_size[u] = ~size;
    req_unsigned[u] = ~uns; req_addr[u] = ~addr; req_wdata[u] = ~wdata;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid[u] && lat < 20);
    rd  = resp_rdata[u];
    mis = resp_misalign[u];
    @(negedge clk);
    pv  = resp_valid[u];
    prd = resp_rdata[u];
  endtask

  task automatic txn(input string tag, input int u, input logic we, input logic [1:0] size,
                     input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rd, input logic exp_mis, input int exp_lat);
    logic [31:0] rd, prd;
    logic        mis, pv;
    int          lat;
    do_req(u, we, size, uns, addr, wdata, rd, mis, lat, pv, prd);
    chk({tag, ".rdata"}, rd, exp_rd);
    chk({tag, ".misalign"}, {31'b0, mis}, {31'b0, exp_mis});
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".pulse_end"}, {31'b0, pv}, 32'd0);
    chk({tag, ".rdata_hold"}, prd, exp_rd);
  endtask

  initial begin
    int acc;
    reset        = 2'b11;
    req_valid    = 2'b00;
    req_we       = 2'b00;
    req_unsigned = 2'b00;
    for (int i = 0; i < 2; i++) begin
      req_size[i] = 2'b10; req_addr[i] = 32'd0; req_wdata[i] = 32'd0;
    end
    dut1.mem[0] = 32'h80F01234;
    dut1.mem[1] = 32'h11223344;
    dut1.mem[2] = 32'hCAFEF00D;

    repeat (2) @(negedge clk);
    chk("rst.ready1", {31'b0, req_ready[1]}, 32'd0);
    chk("rst.ready0", {31'b0, req_ready[0]}, 32'd0);
    chk("rst.valid", {31'b0, resp_valid[1]}, 32'd0);
    chk("rst.busy", {31'b0, busy[1]}, 32'd0);
    chk("rst.rdata", resp_rdata[1], 32'd0);
    chk("rst.mis", {31'b0, resp_misalign[1]}, 32'd0);
    reset = 2'b00;
    @(negedge clk);
    chk("post_rst.ready1", {31'b0, req_ready[1]}, 32'd1);

    // LATENCY = 1: word, byte and half loads from mem[0]
    txn("lw0",   1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h80F01234, 1'b0, 2);
    txn("lw0_s3",1, 1'b0, 2'b11, 1'b1, 32'h0, 32'h0, 32'h80F01234, 1'b0, 2);
    txn("lb3",   1, 1'b0, 2'b00, 1'b0, 32'h3, 32'h0, 32'hFFFFFF80, 1'b0, 2);
    txn("lbu3",  1, 1'b0, 2'b00, 1'b1, 32'h3, 32'h0, 32'h00000080, 1'b0, 2);
    txn("lh2",   1, 1'b0, 2'b01, 1'b0, 32'h2, 32'h0, 32'hFFFF80F0, 1'b0, 2);
    txn("lhu0",  1, 1'b0, 2'b01, 1'b1, 32'h0, 32'h0, 32'h00001234, 1'b0, 2);
    txn("lb1",   1, 1'b0, 2'b00, 1'b0, 32'h1, 32'h0, 32'h00000012, 1'b0, 2);

    // Stores with byte lanes on mem[1]
    txn("sb5",   1, 1'b1, 2'b00, 1'b0, 32'h5, 32'hFFFFFFAB, 32'h0, 1'b0, 2);
    txn("lw4a",  1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h1122AB44, 1'b0, 2);
    txn("sh6",   1, 1'b1, 2'b01, 1'b0, 32'h6, 32'hAAAA1234, 32'h0, 1'b0, 2);
    txn("lw4b",  1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h1234AB44, 1'b0, 2);

    // Misaligned requests fault after one cycle
    txn("lw2_mis", 1, 1'b0, 2'b10, 1'b0, 32'h2, 32'h0, 32'h0, 1'b1, 1);
    txn("lh1_mis", 1, 1'b0, 2'b01, 1'b0, 32'h1, 32'h0, 32'h0, 1'b1, 1);
    txn("sw1_mis", 1, 1'b1, 2'b10, 1'b0, 32'h1, 32'h1234, 32'h0, 1'b1, 1);
    txn("lw0_after_mis", 1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h80F01234, 1'b0, 2);

    // LATENCY = 0 unit
    txn("u0_sw10",   0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h1234, 32'h0, 1'b0, 1);
    txn("u0_lw10",   0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h1234, 1'b0, 1);
    txn("u0_lw1010", 0, 1'b0, 2'b10, 1'b0, 32'h1010, 32'h0, 32'h1234, 1'b0, 1);

    // Back-to-back requests on LATENCY = 0 are accepted every other cycle
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_size[0] = 2'b10; req_addr[0] = 32'h10;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      if (req_ready[0]) acc++;
      @(negedge clk);
    end
    req_valid[0] = 1'b0;
    chk("u0_throughput", 32'(acc), 32'd3);
    @(negedge clk);

    // Reset during WAIT abandons the pending store
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_size[1] = 2'b10;
    req_addr[1] = 32'h8; req_wdata[1] = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0; req_we[1] = 1'b0;
    @(negedge clk);
    chk("wait.busy", {31'b0, busy[1]}, 32'd1);
    reset[1] = 1'b1;
    @(negedge clk);
    chk("rstw.valid", {31'b0, resp_valid[1]}, 32'd0);
    chk("rstw.ready", {31'b0, req_ready[1]}, 32'd0);
    chk("rstw.busy", {31'b0, busy[1]}, 32'd0);
    reset[1] = 1'b0;
    @(negedge clk);
    chk("rstw.valid_after", {31'b0, resp_valid[1]}, 32'd0);
    chk("rstw.ready_after", {31'b0, req_ready[1]}, 32'd1);
    txn("lw8_after_rst", 1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'hCAFEF00D, 1'b0, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
